// File: rtl/fifo_loader_pkg.sv
// Shared types for the fifo_loader block: loader states and a lane-index width helper.
package fifo_loader_pkg;

    typedef enum logic [1:0] {StIdle, StFill, StDrain, StDone} state_e;

    function automatic int unsigned lane_idx_width(input int unsigned dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/fifo_loader_if.sv
// Row handshake plus FIFO-bank control bundle between upstream, fifo_loader and the FIFO bank.
interface fifo_loader_if #(
    parameter int unsigned DIM  = 8,
    parameter int unsigned BITS = 64
);
    logic                start;
    logic                in_valid;
    logic                in_ready;
    logic [DIM*BITS-1:0] in_data;
    logic [DIM-1:0]      fifo_en;
    logic [DIM*BITS-1:0] fifo_d;
    logic                fifo_clr;
    logic [DIM-1:0]      lane_valid;
    logic                busy;
    logic                done;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, fifo_en, fifo_d, fifo_clr, lane_valid, busy, done
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, fifo_en, fifo_d, fifo_clr, lane_valid, busy, done
    );

endinterface

// File: rtl/fifo_loader_skew_window.sv
// Per-lane drain window: lane is active while lane <= k < lane + DEPTH.
module fifo_loader_skew_window
    import fifo_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned KW    = 4,
    parameter int unsigned LW    = 3
) (
    input  logic [KW-1:0] k,
    input  logic [LW-1:0] lane,
    input  logic          active,
    output logic          en
);
    logic [KW-1:0] lo;
    logic [KW-1:0] hi;

    // lane + DEPTH <= DIM + DEPTH - 1, which always fits in KW bits
    assign lo = KW'(lane);
    assign hi = lo + KW'(DEPTH);
    assign en = active && (k >= lo) && (k < hi);

endmodule

// File: rtl/fifo_loader.sv
// Feeds a bank of DIM delay FIFOs: lockstep fill of DEPTH rows, then a diagonally skewed drain.
// Optional FIFO_LOADER_CLR_EN: pulse fifo_clr on the IDLE cycle that accepts start.
module fifo_loader
    import fifo_loader_pkg::*;
#(
    parameter int unsigned DIM   = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned BITS  = 64
) (
    input logic         clk,
    input logic         rst_n,
    fifo_loader_if.slave bus
);
    localparam int unsigned RW = $clog2(DEPTH + 1);
    localparam int unsigned KW = $clog2(DEPTH + DIM);
    localparam int unsigned LW = lane_idx_width(DIM);
    localparam logic [RW-1:0] LastRow = RW'(DEPTH - 1);
    localparam logic [KW-1:0] LastK   = KW'(DEPTH + DIM - 2);

    state_e              state_q, state_d;
    logic [RW-1:0]       row_cnt_q, row_cnt_d;
    logic [KW-1:0]       k_q, k_d;
    logic [DIM-1:0]      window;
    logic [DIM-1:0]      fifo_en;
    logic [DIM-1:0]      lane_valid;
    logic [DIM*BITS-1:0] fifo_d;
    logic                fifo_clr;
    logic                draining;

    assign draining = (state_q == StDrain);

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        fifo_loader_skew_window #(
            .DEPTH (DEPTH),
            .KW    (KW),
            .LW    (LW)
        ) u_win (
            .k      (k_q),
            .lane   (LW'(i)),
            .active (draining),
            .en     (window[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            row_cnt_q <= '0;
            k_q       <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            k_q       <= k_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        k_d        = k_q;
        fifo_en    = '0;
        fifo_d     = '0;
        fifo_clr   = 1'b0;
        lane_valid = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StFill;
                    row_cnt_d = '0;
`ifdef FIFO_LOADER_CLR_EN
                    fifo_clr  = 1'b1;
`endif
                end
            end
            StFill: begin
                if (bus.in_valid) begin
                    fifo_en   = '1;
                    fifo_d    = bus.in_data;
                    row_cnt_d = row_cnt_q + RW'(1);
                    if (row_cnt_q == LastRow) begin
                        state_d = StDrain;
                        k_d     = '0;
                    end
                end
            end
            StDrain: begin
                fifo_en    = window;
                lane_valid = window;
                k_d        = k_q + KW'(1);
                if (k_q == LastK) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.fifo_en    = fifo_en;
    assign bus.fifo_d     = fifo_d;
    // start is a live input, so keep the clear quiet while reset is asserted
    assign bus.fifo_clr   = fifo_clr & rst_n;
    assign bus.lane_valid = lane_valid;
    assign bus.in_ready   = (state_q == StFill);
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = (state_q == StDone);

endmodule

// File: tb/tb_fifo_loader.sv
// Randomised bench for fifo_loader against a row-queue reference model and a modelled FIFO bank.
module tb_fifo_loader;
    localparam int unsigned DIM   = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned BITS  = 8;
    localparam int unsigned W     = DIM * BITS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_loader_if #(.DIM(DIM), .BITS(BITS)) bus ();

    fifo_loader #(
        .DIM   (DIM),
        .DEPTH (DEPTH),
        .BITS  (BITS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase flags, accepted rows and drain index
    bit           m_loading = 1'b0;
    int           m_rows    = 0;
    int           m_k       = -1;
    bit           m_done    = 1'b0;
    logic [W-1:0] m_row_q[$];
    int           m_cycle   = 0;
    bit           last_done = 1'b0;

    // Behavioural FIFO bank driven by the DUT, entry 0 is q
    logic [BITS-1:0] bank [DIM][DEPTH];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DIM-1:0] drain_mask(input int k);
        logic [DIM-1:0] m;
        m = '0;
        for (int i = 0; i < DIM; i++) begin
            if (k >= i && k < i + DEPTH) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic bit m_idle();
        return !m_loading && (m_k < 0) && !m_done;
    endfunction

    task automatic check_all_low(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_fifo_en"}, 64'(bus.fifo_en), 64'd0);
        check({tag, "_fifo_d"}, 64'(bus.fifo_d), 64'd0);
        check({tag, "_lane_valid"}, 64'(bus.lane_valid), 64'd0);
        check({tag, "_fifo_clr"}, 64'(bus.fifo_clr), 64'd0);
    endtask

    task automatic model_reset();
        m_loading = 1'b0;
        m_rows    = 0;
        m_k       = -1;
        m_done    = 1'b0;
    endtask

    // One clock cycle: drive, check at negedge, update model and bank at posedge.
    task automatic tick(input bit s, input bit v, input logic [W-1:0] d);
        logic [DIM-1:0] exp_en, exp_lv, en_s;
        logic [W-1:0]   exp_d, d_s, row;
        bit             exp_clr, clr_s, acc;
        int             idx;
        bus.start    = s;
        bus.in_valid = v;
        bus.in_data  = d;
        @(negedge clk);
        acc    = m_loading && v;
        exp_en = acc ? '1 : ((m_k >= 0) ? drain_mask(m_k) : '0);
        exp_lv = (m_k >= 0) ? drain_mask(m_k) : '0;
        exp_d  = acc ? d : '0;
`ifdef FIFO_LOADER_CLR_EN
        exp_clr = m_idle() && s;
`else
        exp_clr = 1'b0;
`endif
        check("in_ready", 64'(bus.in_ready), 64'(m_loading));
        check("busy", 64'(bus.busy), 64'(!m_idle()));
        check("done", 64'(bus.done), 64'(m_done));
        check("fifo_en", 64'(bus.fifo_en), 64'(exp_en));
        check("fifo_d", 64'(bus.fifo_d), 64'(exp_d));
        check("lane_valid", 64'(bus.lane_valid), 64'(exp_lv));
        check("fifo_clr", 64'(bus.fifo_clr), 64'(exp_clr));
        if (m_k >= 0) begin
            for (int i = 0; i < DIM; i++) begin
                if (m_k - i < DEPTH) begin
                    idx = (m_k > i) ? m_k - i : 0;
                    row = m_row_q[idx];
                    check("lane_q", 64'(bank[i][0]), 64'(row[i*BITS +: BITS]));
                end
            end
        end
        last_done = bus.done;
        en_s  = bus.fifo_en;
        d_s   = bus.fifo_d;
        clr_s = bus.fifo_clr;
        @(posedge clk);
        for (int i = 0; i < DIM; i++) begin
            if (clr_s) begin
                for (int j = 0; j < DEPTH; j++) bank[i][j] = '0;
            end else if (en_s[i]) begin
                for (int j = 0; j < DEPTH - 1; j++) bank[i][j] = bank[i][j+1];
                bank[i][DEPTH-1] = d_s[i*BITS +: BITS];
            end
        end
        if (m_idle()) begin
            if (s) begin
                m_loading = 1'b1;
                m_rows    = 0;
                m_row_q.delete();
            end
        end else if (m_loading) begin
            if (v) begin
                m_row_q.push_back(d);
                m_rows++;
                if (m_rows == DEPTH) begin
                    m_loading = 1'b0;
                    m_k       = 0;
                end
            end
        end else if (m_k >= 0) begin
            m_k++;
            if (m_k == DEPTH + DIM - 1) begin
                m_k    = -1;
                m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
        end
        m_cycle++;
        #1;
    endtask

    task automatic mid_cycle_reset();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_all_low("rst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] tag_row(input int r);
        logic [W-1:0] d;
        logic [3:0]   rr, ii;
        rr = 4'(r);
        for (int i = 0; i < DIM; i++) begin
            ii = 4'(i);
            d[i*BITS +: BITS] = {rr, ii};
        end
        return d;
    endfunction

    function automatic logic [W-1:0] rand_row();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        int  c0, lat, accepts;
        bit  seen, v;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DEPTH; j++) bank[i][j] = '0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #1;
        check_all_low("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of FILL after three rows
        tick(1'b1, 1'b0, '0);
        for (int r = 0; r < 3; r++) tick(1'b0, 1'b1, rand_row());
        mid_cycle_reset();

        // Back-to-back rows tagged {row, lane}, plus start-to-done latency
        c0 = m_cycle;
        tick(1'b1, 1'b0, '0);
        for (int r = 0; r < DEPTH; r++) tick(1'b0, 1'b1, tag_row(r));
        seen = 1'b0;
        lat  = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            tick(1'b0, 1'b0, '0);
            if (last_done) begin
                seen = 1'b1;
                lat  = m_cycle - 1 - c0;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("latency", 64'(lat), 64'(1 + DEPTH + DEPTH + DIM - 1));
        tick(1'b0, 1'b0, '0);

        // in_valid toggled during FILL
        tick(1'b1, 1'b0, '0);
        accepts = 0;
        v = 1'b1;
        for (int n = 0; n < 40 && accepts < DEPTH; n++) begin
            tick(1'b0, v, rand_row());
            if (v) accepts++;
            v = !v;
        end
        for (int n = 0; n < DEPTH + DIM + 1; n++) tick(1'b0, 1'b0, '0);

        // start and in_valid held high through a whole load
        for (int n = 0; n < 1 + DEPTH + DEPTH + DIM; n++) tick(1'b1, 1'b1, rand_row());
        tick(1'b0, 1'b0, '0);
        for (int n = 0; n < 30; n++) tick(1'b0, 1'b0, '0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            tick(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0), rand_row());
        end
        for (int n = 0; n < 40; n++) tick(1'b0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_loader.md
# fifo_loader

Upstream feeder for a bank of DIM delay FIFOs (shift-register, DEPTH entries, BITS wide, oldest entry at q) in the systolic datapath. Accepts DIM-lane rows over a valid/ready handshake, shifts DEPTH rows into all lanes in lockstep, then drains the lanes with a diagonal skew: lane i starts shifting i cycles after lane 0. It generates each lane's shift enable and shift-in data, plus per-lane valid flags for the downstream MAC array.

## Interface
- DIM, 8, number of lanes (FIFOs)
- DEPTH, 8, entries per FIFO; must match the FIFO bank
- BITS, 64, element width
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a load; honoured only in IDLE
- in_valid  input  1  row available
- in_ready  output  1  loader accepts a row
- in_data  input  DIM*BITS  lane i = in_data[i*BITS +: BITS]
- fifo_en  output  DIM  per-lane shift enable
- fifo_d  output  DIM*BITS  per-lane shift-in data, same lane slicing
- fifo_clr  output  1  synchronous clear to all FIFOs
- lane_valid  output  DIM  lane i q holds a valid element this cycle
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at end of drain

## Operation
- States: IDLE, FILL, DRAIN, DONE. Reset -> IDLE, both counters 0.
- IDLE: in_ready=0, fifo_en=0. start=1 -> FILL, row_cnt=0.
- FILL: in_ready=1. On in_valid&&in_ready: fifo_en all 1, fifo_d=in_data, row_cnt++. On the DEPTH-th accepted row -> DRAIN, k=0. No handshake: fifo_en=0, nothing changes.
- DRAIN: in_ready=0, fifo_d=0. For lane i: fifo_en[i] = (k>=i)&&(k<i+DEPTH); lane_valid[i] = same. k increments every cycle; after k = DEPTH+DIM-2 -> DONE.
- DONE: done=1, all enables 0 -> IDLE.
- lane_valid=0 outside DRAIN. Lane i q shows element k-i of its column when valid; element 0 held for k<i.
- start ignored outside IDLE; in_valid ignored outside FILL.
- Counters: row_cnt $clog2(DEPTH+1) bits, k $clog2(DEPTH+DIM) bits; no wrap within a load.
- rst_n low at any point: immediate return to IDLE, counters 0, all outputs low; partial load discarded.

## Timing
- Reset values: in_ready=0, fifo_en=0, fifo_d=0, fifo_clr=0, lane_valid=0, busy=0, done=0.
- in_ready, busy and done decode from registered state only. fifo_en, fifo_d, fifo_clr and lane_valid are combinational from state/counters/handshake; FIFOs capture on the same edge.
- start cycle -> FILL next cycle. Back-to-back rows: one per cycle, min FILL = DEPTH cycles.
- DRAIN lasts exactly DEPTH+DIM-1 cycles. DONE lasts 1 cycle. IDLE is re-entered the cycle after done.
- Min start-to-done latency: 1 + DEPTH + (DEPTH+DIM-1) cycles.

## Configuration
- FIFO_LOADER_CLR_EN defined: fifo_clr=1 in the IDLE cycle where start is accepted, so the FIFOs are zeroed before FILL.
- Undefined: fifo_clr tied 0; FILL overwrites all DEPTH entries, so results are identical.

## Structure
- fifo_loader_pkg: state enum (IDLE, FILL, DRAIN, DONE) and a lane-index width helper.
- Sub-module skew_window: given k, lane index and DEPTH, produces that lane's fifo_en/lane_valid. One instance per lane via generate.

## Test plan
- Reset mid-FILL after 3 rows (DIM=DEPTH=8, BITS=8) -> state IDLE, all outputs 0, in_ready=0; a new start then fills 8 fresh rows.
- start, 8 back-to-back rows with lane i row r = {r,i} -> fifo_en=0xFF for 8 cycles, then DRAIN 15 cycles, done one cycle after the last drain cycle.
- in_valid toggled 1-0-1 during FILL -> fifo_en high only on handshake cycles; DRAIN entered after the 8th accept.
- DRAIN k=0 -> fifo_en=0x01; k=7 -> 0xFF; k=8 -> 0xFE; k=14 -> 0x80. lane_valid matches fifo_en every cycle.
- start pulsed during FILL/DRAIN, in_valid high during DRAIN -> no state change, no extra shifts.
- With FIFO_LOADER_CLR_EN: fifo_clr=1 exactly on the start-accept cycle. Without it: fifo_clr stays 0, and drained lane data is identical in both builds.
